// File: rtl/avalon_arb_pkg.sv
// rtl/avalon_arb_pkg.sv - shared types and constants for the round-robin Avalon-MM arbiter
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEFAULT = 24;
  localparam int DATA_W_DEFAULT = 16;
  localparam int BE_W           = 2;
  localparam int WD_CNT_W       = 8;

  // SDRAM occupies the upper half of the address map (addr[23] = 1)
  localparam logic [23:0] SDRAM_BASE = 24'h800000;

endpackage

// File: rtl/avalon_rr_pick.sv
// rtl/avalon_rr_pick.sv - combinational rotate-priority picker (first requester after last_grant)
module avalon_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   index_o
);

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % NUM_REQ]) begin
        valid_o = 1'b1;
        index_o = IDX_W'((int'(last_i) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/avalon_rr_arbiter.sv
// rtl/avalon_rr_arbiter.sv - round-robin arbiter sharing one Avalon-MM master port; optional AVALON_ARB_TIMEOUT_EN watchdog
module avalon_rr_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [NUM_REQ-1:0]      iREQ,
  input  logic [NUM_REQ-1:0]      iRD_NWR,
  input  logic [NUM_REQ*ADDR_W-1:0] iADDR,
  input  logic [NUM_REQ*DATA_W-1:0] iDATA,
  input  logic [NUM_REQ*BE_W-1:0] iBE,
  output logic [NUM_REQ-1:0]      oDONE,
  output logic [DATA_W-1:0]       oRDATA,
  output logic                    oERR,
  output logic                    oBUSY,
  output logic [ADDR_W-1:0]       oAddr,
  output logic                    oRead,
  output logic                    oWrite,
  output logic [BE_W-1:0]         oBE,
  output logic [DATA_W-1:0]       oData,
  input  logic                    iWaitRequest,
  input  logic [DATA_W-1:0]       iReadData
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  g_q;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_q;
  logic              err_q;

  avalon_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (iREQ),
    .last_i  (last_grant_q),
    .valid_o (pick_valid),
    .index_o (pick_idx)
  );

`ifdef AVALON_ARB_TIMEOUT_EN
  logic [WD_CNT_W-1:0] wd_cnt_q;

  // Watchdog: counts stalled ISSUE cycles, cleared whenever not issuing
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wd_cnt_q <= '0;
    end else if (state_q != ST_ISSUE) begin
      wd_cnt_q <= '0;
    end else if (iWaitRequest) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_ISSUE) && iWaitRequest &&
                       (wd_cnt_q == WD_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: IDLE -> ISSUE -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (!iWaitRequest || timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Transaction latches: captured at grant, read data at completion, last grant at DONE
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      g_q          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      rd_q         <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            g_q    <= pick_idx;
            addr_q <= iADDR[pick_idx*ADDR_W +: ADDR_W];
            data_q <= iDATA[pick_idx*DATA_W +: DATA_W];
            be_q   <= iBE[pick_idx*BE_W +: BE_W];
            rd_q   <= iRD_NWR[pick_idx];
          end
        end
        ST_ISSUE: begin
          if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (!iWaitRequest) begin
            rdata_q <= rd_q ? iReadData : '0;
            err_q   <= 1'b0;
          end
        end
        ST_DONE: last_grant_q <= g_q;
        default: ;
      endcase
    end
  end

  // Bus strobes come only from latches and only while issuing; done pulse decoded from grant
  always_comb begin
    oRead  = 1'b0;
    oWrite = 1'b0;
    oAddr  = '0;
    oData  = '0;
    oBE    = '0;
    oDONE  = '0;
    if (state_q == ST_ISSUE) begin
      oRead  = rd_q;
      oWrite = !rd_q;
      oAddr  = addr_q;
      oData  = data_q;
      oBE    = be_q;
    end
    if (state_q == ST_DONE) oDONE[g_q] = 1'b1;
  end

  assign oBUSY  = (state_q != ST_IDLE);
  assign oRDATA = rdata_q;
  assign oERR   = err_q;

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// tb/tb_avalon_rr_arbiter.sv - self-checking bench for avalon_rr_arbiter (honours AVALON_ARB_TIMEOUT_EN)
module tb_avalon_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic [N-1:0]  iREQ = '0;
  logic [N-1:0]  iRD_NWR = '0;
  logic [N*AW-1:0] iADDR = '0;
  logic [N*DW-1:0] iDATA = '0;
  logic [N*2-1:0]  iBE = '0;
  logic [N-1:0]  oDONE;
  logic [DW-1:0] oRDATA;
  logic          oERR;
  logic          oBUSY;
  logic [AW-1:0] oAddr;
  logic          oRead;
  logic          oWrite;
  logic [1:0]    oBE;
  logic [DW-1:0] oData;
  logic          iWaitRequest = 1'b0;
  logic [DW-1:0] iReadData = '0;

  int errors = 0;
  int checks = 0;
  int exp_last = N - 1;

  avalon_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(255)) dut (
    .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iRD_NWR(iRD_NWR), .iADDR(iADDR),
    .iDATA(iDATA), .iBE(iBE), .oDONE(oDONE), .oRDATA(oRDATA), .oERR(oERR),
    .oBUSY(oBUSY), .oAddr(oAddr), .oRead(oRead), .oWrite(oWrite), .oBE(oBE),
    .oData(oData), .iWaitRequest(iWaitRequest), .iReadData(iReadData)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Round-robin rule: first requester found walking upward from the last grant, wrapping
  function automatic int model_pick(input logic [N-1:0] req, input int last);
    for (int off = 1; off <= N; off++) begin
      if (req[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic scramble_inputs();
    iADDR   = {$urandom, $urandom, $urandom};
    iDATA   = {$urandom, $urandom};
    iBE     = N*2'($urandom);
    iRD_NWR = N'($urandom);
  endtask

  // One arbitrated transaction starting in an IDLE cycle; expectations from the model
  task automatic run_txn(input int waits, input bit drop_req, input bit scramble, output int g);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] erd;
    logic [1:0]    eb;
    logic          er;
    g = model_pick(iREQ, exp_last);
    if (g < 0) return;
    ea  = iADDR[g*AW +: AW];
    ed  = iDATA[g*DW +: DW];
    eb  = iBE[g*2 +: 2];
    er  = iRD_NWR[g];
    erd = '0;
    checks++;
    if (oBUSY !== 1'b0 || oDONE !== '0) begin
      errors++;
      $display("FAIL idle_state: busy=%b done=%b required busy=0 done=0", oBUSY, oDONE);
    end
    step();
    for (int c = 0; c <= waits; c++) begin
      iWaitRequest = (c < waits);
      iReadData    = DW'($urandom);
      if (scramble) scramble_inputs();
      if (drop_req) iREQ[g] = 1'b0;
      checks++;
      if (oRead !== er || oWrite !== !er || oAddr !== ea || oData !== ed || oBE !== eb ||
          oDONE !== '0 || oBUSY !== 1'b1) begin
        errors++;
        $display("FAIL issue_bus c=%0d: rd=%b wr=%b addr=%h data=%h be=%b done=%b required rd=%b wr=%b addr=%h data=%h be=%b done=0",
                 c, oRead, oWrite, oAddr, oData, oBE, oDONE, er, !er, ea, ed, eb);
      end
      erd = er ? iReadData : '0;
      step();
    end
    iWaitRequest = 1'b0;
    checks++;
    if (oDONE !== N'(1 << g) || oRDATA !== erd || oERR !== 1'b0 || oRead !== 1'b0 ||
        oWrite !== 1'b0 || oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done=%b rdata=%h err=%b rd=%b wr=%b required done=%b rdata=%h err=0",
               oDONE, oRDATA, oERR, oRead, oWrite, N'(1 << g), erd);
    end
    iREQ[g]  = 1'b0;
    exp_last = g;
    step();
    checks++;
    if (oDONE !== '0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b required done=0 busy=0", oDONE, oBUSY);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    #3;
    checks++;
    if (oBUSY !== 1'b0 || oDONE !== '0 || oRead !== 1'b0 || oWrite !== 1'b0 || oBE !== 2'b00 ||
        oAddr !== '0 || oData !== '0 || oRDATA !== '0 || oERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b be=%b addr=%h rdata=%h err=%b required all 0",
               oBUSY, oDONE, oRead, oWrite, oBE, oAddr, oRDATA, oERR);
    end
    step();
    step();
    iRST = 1'b0;
    exp_last = N - 1;
    step();
  endtask

  task automatic test_single_read();
    iADDR = '0;
    iADDR[AW-1:0] = 24'h000010;
    iBE[1:0]      = 2'b11;
    iRD_NWR       = 4'b0001;
    iReadData     = 16'hBEEF;
    iWaitRequest  = 1'b0;
    iREQ          = 4'b0001;
    checks++;
    if (oRead !== 1'b0) begin
      errors++;
      $display("FAIL sr_cycle0: rd=%b required 0", oRead);
    end
    step();
    checks++;
    if (oRead !== 1'b1 || oAddr !== 24'h000010 || oBE !== 2'b11 || oDONE !== '0) begin
      errors++;
      $display("FAIL sr_cycle1: rd=%b addr=%h be=%b done=%b required rd=1 addr=000010 be=11 done=0",
               oRead, oAddr, oBE, oDONE);
    end
    step();
    checks++;
    if (oDONE !== 4'b0001 || oRDATA !== 16'hBEEF || oRead !== 1'b0) begin
      errors++;
      $display("FAIL sr_cycle2: done=%b rdata=%h rd=%b required done=0001 rdata=beef rd=0",
               oDONE, oRDATA, oRead);
    end
    iREQ = '0;
    exp_last = 0;
    step();
    checks++;
    if (oDONE !== '0 || oBUSY !== 1'b0 || oRDATA !== 16'hBEEF) begin
      errors++;
      $display("FAIL sr_after: done=%b busy=%b rdata=%h required done=0 busy=0 rdata=beef",
               oDONE, oBUSY, oRDATA);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int order[4];
    int t0;
    scramble_inputs();
    // restart from a known last grant so the order must be 0,1,2,3
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    exp_last = N - 1;
    iREQ = 4'b1111;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b0, 1'b0, g);
      order[i] = g;
    end
    checks++;
    if (order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || ($time - t0) != 120) begin
      errors++;
      $display("FAIL rr_order: order=%0d%0d%0d%0d time=%0t required 0123 time=120",
               order[0], order[1], order[2], order[3], $time - t0);
    end
  endtask

  task automatic test_wrap();
    int g;
    scramble_inputs();
    iREQ = 4'b1001;
    run_txn(0, 1'b0, 1'b0, g);
    run_txn(1, 1'b0, 1'b0, g);
  endtask

  task automatic test_wait_write();
    int g;
    scramble_inputs();
    iRD_NWR[2] = 1'b0;
    iREQ = 4'b0100;
    run_txn(5, 1'b0, 1'b1, g);
  endtask

  task automatic test_random();
    int g;
    for (int t = 0; t < 40; t++) begin
      iREQ = iREQ | N'($urandom);
      if (iREQ == '0) iREQ[$urandom_range(0, N-1)] = 1'b1;
      scramble_inputs();
      run_txn($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b1, g);
    end
    iREQ = '0;
  endtask

  task automatic test_reset_mid();
    int g;
    iRD_NWR = 4'b1111;
    iREQ = 4'b0100;
    iWaitRequest = 1'b1;
    step();
    #2;
    iRST = 1'b1;
    #1;
    checks++;
    if (oRead !== 1'b0 || oAddr !== '0 || oBUSY !== 1'b0 || oBE !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: rd=%b addr=%h busy=%b be=%b required all 0", oRead, oAddr, oBUSY, oBE);
    end
    step();
    iRST = 1'b0;
    iWaitRequest = 1'b0;
    exp_last = N - 1;
    iREQ = 4'b1111;
    scramble_inputs();
    run_txn(0, 1'b0, 1'b0, g);
    iREQ = '0;
    step();
  endtask

  task automatic test_timeout();
    int bad;
    int g;
    bad = 0;
    iRD_NWR = 4'b0001;
    iReadData = 16'hFFFF;
    iREQ = 4'b0001;
    step();
    iWaitRequest = 1'b1;
`ifdef AVALON_ARB_TIMEOUT_EN
    for (int c = 0; c < 255; c++) begin
      if (oDONE !== '0 || oRead !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_wait: %0d early cycles required 0", bad);
    end
    checks++;
    if (oDONE !== 4'b0001 || oERR !== 1'b1 || oRDATA !== '0 || oRead !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done: done=%b err=%b rdata=%h rd=%b required done=0001 err=1 rdata=0000 rd=0",
               oDONE, oERR, oRDATA, oRead);
    end
    iREQ = '0;
    iWaitRequest = 1'b0;
    exp_last = 0;
    step();
    iREQ = 4'b0010;
    scramble_inputs();
    run_txn(0, 1'b0, 1'b0, g);
`else
    for (int c = 0; c < 300; c++) begin
      if (oDONE !== '0 || oBUSY !== 1'b1 || oRead !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || oERR !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: %0d bad cycles err=%b required 0 bad cycles err=0", bad, oERR);
    end
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    iWaitRequest = 1'b0;
    iREQ = '0;
    exp_last = N - 1;
    step();
    g = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wrap();
    test_wait_write();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
